// File: rtl/mat_exec_pkg.sv
// Shared types, op-word layout and helpers for mat_exec_sequencer.
// Optional feature in the top: MXS_TIMEOUT_EN (handshake timeout).
package mat_exec_pkg;

   typedef enum logic [3:0] {
      OPC_STOP = 4'd0,
      OPC_ADD  = 4'd1,
      OPC_SUB  = 4'd2,
      OPC_MUL  = 4'd3,
      OPC_SCA  = 4'd4,
      OPC_TRA  = 4'd5
   } opc_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_RD_A,
      S_RD_B,
      S_EXEC,
      S_WB_REG,
      S_WB_MEM,
      S_HALT,
      S_ERR
   } state_e;

   localparam int OPC_LSB   = 28;
   localparam int OPC_W     = 4;
   localparam int DST_LSB   = 26;
   localparam int DST_W     = 2;
   localparam int DADDR_LSB = 18;
   localparam int FADDR_W   = 8;
   localparam int S1_BIT    = 17;
   localparam int A1_LSB    = 9;
   localparam int S2_BIT    = 8;
   localparam int A2_LSB    = 0;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OPC     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef struct packed {
      opc_e               opc;
      logic [DST_W-1:0]   dst;
      logic [FADDR_W-1:0] daddr;
      logic               s1reg;
      logic [FADDR_W-1:0] a1;
      logic               s2reg;
      logic [FADDR_W-1:0] a2;
   } op_fields_t;

   localparam int DIAG_MAX_N = 16;
   localparam int DIAG_MAX_W = DIAG_MAX_N * DIAG_MAX_N * 32;
   localparam int DIAG_IW    = $clog2(DIAG_MAX_W);

   // Callers slice the low n*n*ew bits; the wide return keeps N/EW free.
   function automatic logic [DIAG_MAX_W-1:0] diag_matrix(
      input int         n,
      input int         ew,
      input logic [7:0] scalar
   );
      logic [DIAG_MAX_W-1:0] m;
      logic [DIAG_IW-1:0]    idx;
      m = '0;
      for (int i = 0; i < DIAG_MAX_N; i++) begin
         for (int b = 0; b < 8; b++) begin
            if (i < n && b < ew) begin
               idx    = DIAG_IW'((i * n + i) * ew + b);
               m[idx] = scalar[3'(b)];
            end
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/mat_op_decode.sv
// Combinational split of a 32-bit matrix op word into fields.
// Flags opcodes outside STOP..TRA as illegal.
module mat_op_decode
   import mat_exec_pkg::*;
(
   input  logic [31:0] op_i,
   output op_fields_t  f_o,
   output logic        legal_o
);

   always_comb begin
      f_o.opc   = opc_e'(op_i[OPC_LSB +: OPC_W]);
      f_o.dst   = op_i[DST_LSB +: DST_W];
      f_o.daddr = op_i[DADDR_LSB +: FADDR_W];
      f_o.s1reg = op_i[S1_BIT];
      f_o.a1    = op_i[A1_LSB +: FADDR_W];
      f_o.s2reg = op_i[S2_BIT];
      f_o.a2    = op_i[A2_LSB +: FADDR_W];
      legal_o   = (op_i[OPC_LSB +: OPC_W] <= OPC_TRA);
   end

endmodule

// File: rtl/mat_exec_sequencer.sv
// Matrix-instruction sequencer: fetch, decode, operand read, FU dispatch, writeback.
// Define MXS_TIMEOUT_EN to abort any handshake stalled for TO_CYC cycles.
module mat_exec_sequencer
   import mat_exec_pkg::*;
#(
   parameter int N      = 4,
   parameter int EW     = 16,
   parameter int AW     = 8,
   parameter int PCW    = 4,
   parameter int TO_CYC = 64
) (
   input  logic                clk,
   input  logic                RESET,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [PCW-1:0]      op_addr,
   output logic                op_req,
   input  logic                op_ack,
   input  logic [31:0]         op_data,
   output logic [AW-1:0]       mem_addr,
   output logic                mem_we,
   output logic                mem_req,
   input  logic                mem_ack,
   output logic [N*N*EW-1:0]   mem_wdata,
   input  logic [N*N*EW-1:0]   mem_rdata,
   output logic                reg_we,
   output logic                reg_req,
   input  logic                reg_ack,
   output logic [N*N*EW-1:0]   reg_wdata,
   input  logic [N*N*EW-1:0]   reg_rdata,
   output logic [3:0]          fu_op,
   output logic [N*N*EW-1:0]   fu_a,
   output logic [N*N*EW-1:0]   fu_b,
   output logic                fu_req,
   input  logic                fu_ack,
   input  logic [N*N*EW-1:0]   fu_result
);

   localparam int MAT_W = N * N * EW;

   state_e           state_q, state_d;
   logic [PCW-1:0]   pc_q, pc_d;
   logic [31:0]      op_q, op_d;
   logic [MAT_W-1:0] a_q, a_d;
   logic [MAT_W-1:0] b_q, b_d;
   logic [MAT_W-1:0] res_q, res_d;
   logic [1:0]       errc_q, errc_d;
   logic             gap_q, gap_d;

   op_fields_t       f;
   logic             legal;
   logic             two_src;
   logic [MAT_W-1:0] diag_b;

   mat_op_decode u_dec (
      .op_i    (op_q),
      .f_o     (f),
      .legal_o (legal)
   );

   assign two_src  = f.opc inside {OPC_ADD, OPC_SUB, OPC_MUL};
   assign diag_b   = MAT_W'(diag_matrix(N, EW, f.a2));
   assign busy     = !(state_q inside {S_IDLE, S_HALT, S_ERR});
   assign done     = (state_q == S_HALT);
   assign err      = (state_q == S_ERR);
   assign err_code = errc_q;
   assign op_addr  = pc_q;

`ifdef MXS_TIMEOUT_EN
   localparam int TOW = $clog2(TO_CYC + 1);
   logic [TOW-1:0] to_q, to_d;
   logic           req_any, ack_any;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      errc_d    = errc_q;
      gap_d     = gap_q;
      op_req    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      reg_req   = 1'b0;
      reg_we    = 1'b0;
      reg_wdata = '0;
      fu_req    = 1'b0;
      fu_op     = '0;
      fu_a      = '0;
      fu_b      = '0;
      unique case (state_q)
         S_IDLE, S_HALT, S_ERR: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
               errc_d  = ERR_NONE;
            end
         end
         S_FETCH: begin
            op_req = 1'b1;
            if (op_ack) begin
               op_d    = op_data;
               pc_d    = pc_q + PCW'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!legal) begin
               state_d = S_ERR;
               errc_d  = ERR_OPC;
            end else if (f.opc == OPC_STOP) begin
               state_d = S_HALT;
            end else begin
               state_d = S_RD_A;
            end
         end
         S_RD_A: begin
            reg_req  = f.s1reg;
            mem_req  = !f.s1reg;
            mem_addr = f.s1reg ? '0 : AW'(f.a1);
            if (f.s1reg ? reg_ack : mem_ack) begin
               a_d     = f.s1reg ? reg_rdata : mem_rdata;
               state_d = two_src ? S_RD_B : S_EXEC;
               // back-to-back reads of one port get an idle cycle so req drops
               gap_d   = two_src && (f.s1reg == f.s2reg);
            end
         end
         S_RD_B: begin
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               reg_req  = f.s2reg;
               mem_req  = !f.s2reg;
               mem_addr = f.s2reg ? '0 : AW'(f.a2);
               if (f.s2reg ? reg_ack : mem_ack) begin
                  b_d     = f.s2reg ? reg_rdata : mem_rdata;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            fu_req = 1'b1;
            fu_op  = f.opc;
            fu_a   = a_q;
            fu_b   = (f.opc == OPC_SCA) ? diag_b :
                     (f.opc == OPC_TRA) ? '0 : b_q;
            if (fu_ack) begin
               res_d   = fu_result;
               state_d = f.dst[1] ? S_WB_REG :
                         f.dst[0] ? S_WB_MEM : S_FETCH;
            end
         end
         S_WB_REG: begin
            reg_req   = 1'b1;
            reg_we    = 1'b1;
            reg_wdata = res_q;
            if (reg_ack) state_d = f.dst[0] ? S_WB_MEM : S_FETCH;
         end
         S_WB_MEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = AW'(f.daddr);
            mem_wdata = res_q;
            if (mem_ack) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef MXS_TIMEOUT_EN
      req_any = op_req | mem_req | reg_req | fu_req;
      ack_any = (op_req & op_ack) | (mem_req & mem_ack) |
                (reg_req & reg_ack) | (fu_req & fu_ack);
      to_d    = (req_any && !ack_any) ? to_q + TOW'(1) : '0;
      if (req_any && !ack_any && to_q == TOW'(TO_CYC - 1)) begin
         state_d = S_ERR;
         errc_d  = ERR_TIMEOUT;
         to_d    = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         errc_q  <= ERR_NONE;
         gap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         errc_q  <= errc_d;
         gap_q   <= gap_d;
      end
   end

`ifdef MXS_TIMEOUT_EN
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) to_q <= '0;
      else        to_q <= to_d;
   end
`endif

endmodule
